// File: rtl/can_clic_seq_if.sv
// Claim/config bundle between the CLIC arbiter and the core.
// Master is the core side, slave is the arbiter.
interface can_clic_seq_if #(
  parameter int N_SRC     = 8,
  parameter int PRIO_BITS = 3
);
  localparam int INDEX_BITS = $clog2(N_SRC);

  logic [N_SRC-1:0]      irq_in;
  logic                  cfg_we;
  logic [INDEX_BITS-1:0] cfg_idx;
  logic [PRIO_BITS-1:0]  cfg_prio;
  logic                  cfg_ie;
  logic [PRIO_BITS-1:0]  threshold;
  logic                  irq_ack;
  logic                  irq_valid;
  logic [INDEX_BITS-1:0] irq_index;
  logic [PRIO_BITS-1:0]  irq_prio;
  logic                  arb_busy;

  modport master (
    output irq_in, cfg_we, cfg_idx, cfg_prio,
    output cfg_ie, threshold, irq_ack,
    input  irq_valid, irq_index, irq_prio,
    input  arb_busy
  );

  modport slave (
    input  irq_in, cfg_we, cfg_idx, cfg_prio,
    input  cfg_ie, threshold, irq_ack,
    output irq_valid, irq_index, irq_prio,
    output arb_busy
  );
endinterface

// File: rtl/can_clic_seq.sv
// Clocked CLIC: bit-serial wired-OR arbitration over {prio, index},
// MSB first, winner presented through a valid/ack claim handshake.
module can_clic_seq #(
  parameter int N_SRC     = 8,
  parameter int PRIO_BITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  can_clic_seq_if.slave bus
);
  localparam int INDEX_BITS = $clog2(N_SRC);
  localparam int K          = PRIO_BITS + INDEX_BITS;
  localparam int CW         = $clog2(K);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    PRESENT
  } state_t;

  state_t state, state_n;

  logic [N_SRC-1:0]      pending, ie, irq_q;
  logic [N_SRC-1:0]      contender, cont_n;
  logic [N_SRC-1:0]      kb, rise, clr, elig;
  logic [PRIO_BITS-1:0]  prio      [N_SRC];
  logic [PRIO_BITS-1:0]  prio_snap [N_SRC];
  logic [CW-1:0]         cnt;
  logic [K-1:0]          key_acc, win_key, key;
  logic                  or_v;
  logic [PRIO_BITS-1:0]  win_prio;
  logic [INDEX_BITS-1:0] win_idx;
  logic                  arb_done, win_ok, dis_hit;
  logic                  valid_q, busy_q;
  logic [INDEX_BITS-1:0] index_q;
  logic [PRIO_BITS-1:0]  prio_q;

  assign elig     = pending & ie;
  assign rise     = bus.irq_in & ~irq_q;
  assign arb_done = (cnt == '0);
  assign win_prio = win_key[K-1:INDEX_BITS];
  assign win_idx  = win_key[INDEX_BITS-1:0];
  assign win_ok   = win_prio > bus.threshold;
  assign dis_hit  = bus.cfg_we && !bus.cfg_ie
                  && (bus.cfg_idx == index_q)
                  && !bus.irq_ack;

  assign bus.irq_valid = valid_q;
  assign bus.irq_index = index_q;
  assign bus.irq_prio  = prio_q;
  assign bus.arb_busy  = busy_q;

  // The winner's key bit at each position equals the wired-OR,
  // so the winning key accumulates without an encoder.
  always_comb begin
    or_v = 1'b0;
    kb   = '0;
    key  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      key   = {prio_snap[i], INDEX_BITS'(i)};
      kb[i] = key[cnt];
      or_v  = or_v | (contender[i] & kb[i]);
    end
    cont_n       = contender & ~({N_SRC{or_v}} & ~kb);
    win_key      = key_acc;
    win_key[cnt] = or_v;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|elig) state_n = ARB;
      ARB:     if (arb_done)
                 state_n = win_ok ? PRESENT : IDLE;
      PRESENT: if (bus.irq_ack || dis_hit)
                 state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    if (state == PRESENT && bus.irq_ack)
      clr[index_q] = 1'b1;
  end

  // A rising edge beats an ack clear so the new event survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ie      <= '0;
      irq_q   <= '0;
      for (int i = 0; i < N_SRC; i++)
        prio[i] <= '0;
    end else begin
      irq_q   <= bus.irq_in;
      pending <= (pending & ~clr) | rise;
      for (int i = 0; i < N_SRC; i++) begin
        if (bus.cfg_we && bus.cfg_idx == INDEX_BITS'(i)) begin
          prio[i] <= bus.cfg_prio;
          ie[i]   <= bus.cfg_ie;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      contender <= '0;
      cnt       <= '0;
      key_acc   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      index_q   <= '0;
      prio_q    <= '0;
      for (int i = 0; i < N_SRC; i++)
        prio_snap[i] <= '0;
    end else begin
      state   <= state_n;
      valid_q <= (state_n == PRESENT);
      busy_q  <= (state_n == ARB);
      if (state == IDLE && |elig) begin
        contender <= elig;
        cnt       <= CW'(K - 1);
        key_acc   <= '0;
        for (int i = 0; i < N_SRC; i++)
          prio_snap[i] <= prio[i];
      end
      if (state == ARB) begin
        contender <= cont_n;
        key_acc   <= win_key;
        if (!arb_done) cnt <= cnt - CW'(1);
      end
      if (state == ARB && arb_done && win_ok) begin
        index_q <= win_idx;
        prio_q  <= win_prio;
      end else if (state_n != PRESENT) begin
        index_q <= '0;
        prio_q  <= '0;
      end
    end
  end
endmodule
